icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped, read-only instruction cache between the fetch stage and the memory controller's instruction port. It serves fetch reads in the same cycle on a hit. On a miss it issues a single-word read to the memory controller, holds that read until the controller drops `iwait`, fills the line and returns to lookup. Word-granular lines; no write path, no coherence.

## Interface
- `SETS`, 16: number of lines, power of two ≥ 2; index width `IDX = log2(SETS)`.
- Address split: byte offset `[1:0]` ignored; index `[IDX+1:2]`; tag `[31:IDX+2]`.

- `CLK`  in  1  sole clock; all state updates on rising edge.
- `RST`  in  1  reset; one clock, synchronous, active-high.
- `imemREN`  in  1  fetch read request from datapath.
- `imemaddr`  in  32  fetch address.
- `ihit`  out  1  fetch data valid this cycle.
- `imemload`  out  32  fetch instruction word.
- `iREN`  out  1  read request to memory controller.
- `iaddr`  out  32  read address to memory controller, word-aligned.
- `iwait`  in  1  controller busy; 0 means `iload` is valid this cycle.
- `iload`  in  32  read data from controller.

## Operation
- Storage per line: `valid` (1), `tag` (32-IDX-2), `data` (32). All `valid` bits are cleared on reset; tag and data are not reset.
- Hit (combinational): `hit = imemREN & valid[idx] & (tag[idx] == imemaddr tag)`, evaluated only in state IDLE.
- FSM states: IDLE and FILL.
  - IDLE: `iREN=0`. `ihit=hit`. `imemload=data[idx]` when hit, else 0.
  - IDLE → FILL when `imemREN & !hit`; latch `miss_addr = {imemaddr[31:2],2'b00}`.
  - FILL: `iREN=1`, `iaddr=miss_addr`, `ihit=0`, `imemload=0`.
  - FILL → IDLE when `iwait==0`. On that edge write `data=iload`, `tag=miss_addr tag`, `valid=1` at `miss_addr` index.
- A fill always completes to `miss_addr`, even if `imemaddr` or `imemREN` changes during FILL; a redirected fetch simply misses or hits afterwards.
- Conflict: a fill overwrites the resident line at that index unconditionally; no dirty state.
- Outputs in IDLE with `imemREN=0`: `ihit=0`, `iREN=0`, `imemload=0`.
- `iaddr` in IDLE is driven to `miss_addr`. It is don't-care to the controller while `iREN=0`.

## Timing
- Reset: on any edge with `RST=1`, state → IDLE, all `valid` → 0, `miss_addr` → 0. The outputs are then `iREN=0`, `ihit=0`, `imemload=0`, `iaddr=0`.
- Reset during FILL abandons the fill: no line is written, and `iREN` is low from the cycle after the reset edge.
- Hit latency: 0 cycles. `ihit` is in the same cycle as `imemREN`/`imemaddr`.
- Miss latency: the miss is detected in cycle 0. Cycles 1..N are FILL, where N is the number of cycles until `iwait=0`, with N ≥ 1. Cycle N+1 is IDLE and hits. The total is N+2 cycles from request to `ihit`.
- `iREN` rises exactly one cycle after miss detection. It stays high continuously through FILL, including the `iwait=0` cycle, and falls the cycle after.
- `iwait=0` is sampled only in FILL; `iwait` in IDLE is ignored.
- `RST` overrides a fill completing on the same edge.
- Single outstanding miss; no prefetch, no bypass of `iload` to `imemload`.

## Test plan
- Cold miss: reset, then `imemREN=1`, `imemaddr=0x00000004`, controller returns `0xDEADBEEF` after 2 `iwait` cycles. Required: `iREN` high with `iaddr=0x4` for 3 cycles, `ihit=1` with `imemload=0xDEADBEEF` in cycle 4, and no further `iREN`.
- Repeat hit: after the cold miss, fetch `0x4` again and then `0x6`. Required: `ihit=1` and `0xDEADBEEF` in the same cycle for both, with `iREN=0`.
- Conflict: with `SETS=16`, fill `0x00` = `0x11111111`, then `0x40` = `0x22222222`, then fetch `0x00`. Required: the `0x00` fetch misses, `iaddr=0x00` is re-issued, and the fill returns `0x11111111`.
- Redirect during FILL: miss on `0x8`, then change `imemaddr` to `0xC` while in FILL. Required: the fill completes to `0x8`. Then `0xC` misses and issues `iaddr=0xC`. A later fetch of `0x8` hits.
- Reset mid-FILL: assert `RST` for 1 cycle while `iwait=1`. Required: `iREN=0` next cycle. A subsequent fetch of the same address misses.
- Idle: `imemREN=0` for 10 cycles with random `imemaddr`. Required: `iREN=0`, `ihit=0`, `imemload=0` throughout.

Source files
------------

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache with word-sized lines.
// Hits return data combinationally in IDLE; a miss holds a single-word read in FILL
// until the controller drops iwait, then writes the line and returns to IDLE.
module icache_direct #(
  parameter int unsigned SETS = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int unsigned IDX  = $clog2(SETS);
  localparam int unsigned TAGW = 32 - IDX - 2;

  typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [SETS-1:0]   r_valid;
  logic [TAGW-1:0]   r_tag  [SETS];
  logic [31:0]       r_data [SETS];
  logic [31:0]       r_miss_addr;

  logic [IDX-1:0]    w_idx;
  logic [TAGW-1:0]   w_tag;
  logic [IDX-1:0]    w_fill_idx;
  logic [TAGW-1:0]   w_fill_tag;
  logic              w_hit;
  logic              w_miss;
  logic              w_fill_done;
  logic              w_unused;

  assign w_idx       = imemaddr[IDX+1:2];
  assign w_tag       = imemaddr[31:IDX+2];
  assign w_fill_idx  = r_miss_addr[IDX+1:2];
  assign w_fill_tag  = r_miss_addr[31:IDX+2];
  assign w_hit       = imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_miss      = (r_state == S_IDLE) & imemREN & ~w_hit;
  assign w_fill_done = (r_state == S_FILL) & ~iwait;
  // Byte offset does not take part in lookup.
  assign w_unused    = ^imemaddr[1:0];

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic: miss starts a fill, controller ready ends it.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_miss)      w_next_state = S_FILL;
      S_FILL:  if (w_fill_done) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Valid bits and miss address; reset abandons any fill in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid     <= '0;
      r_miss_addr <= '0;
    end else begin
      if (w_miss)      r_miss_addr <= {imemaddr[31:2], 2'b00};
      if (w_fill_done) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; valid gates their use.
  always_ff @(posedge CLK) begin
    if (!RST && w_fill_done) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= iload;
    end
  end

  // Output logic: hit data in IDLE, memory request in FILL.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = r_miss_addr;
    case (r_state)
      S_IDLE: begin
        ihit     = w_hit;
        imemload = w_hit ? r_data[w_idx] : 32'h0;
      end
      S_FILL:  iREN = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: cycle-by-cycle vector table for icache_direct plus
// hand-written idle and long-miss-latency sequences.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  int checks   = 0;
  int failures = 0;

  icache_direct #(.SETS(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        iw;
    logic [31:0] ld;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic rst, logic ren, logic [31:0] addr, logic iw,
                              logic [31:0] ld, logic e_hit, logic [31:0] e_load,
                              logic e_ren, logic [31:0] e_addr);
    vec_t v;
    v.rst = rst; v.ren = ren; v.addr = addr; v.iw = iw; v.ld = ld;
    v.e_hit = e_hit; v.e_load = e_load; v.e_ren = e_ren; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    // rst ren addr iw ld | hit load iren iaddr
    // reset state
    tv.push_back(mk(0,0,32'h00,0,32'h0,        0,32'h0,        0,32'h00));
    // cold miss on 0x4, two iwait cycles
    tv.push_back(mk(0,1,32'h04,1,32'h0,        0,32'h0,        0,32'h00));
    tv.push_back(mk(0,1,32'h04,1,32'h0,        0,32'h0,        1,32'h04));
    tv.push_back(mk(0,1,32'h04,1,32'h0,        0,32'h0,        1,32'h04));
    tv.push_back(mk(0,1,32'h04,0,32'hDEADBEEF, 0,32'h0,        1,32'h04));
    tv.push_back(mk(0,1,32'h04,1,32'h0,        1,32'hDEADBEEF, 0,32'h04));
    // repeat hits, byte offset ignored, iwait ignored in IDLE
    tv.push_back(mk(0,1,32'h06,0,32'h0,        1,32'hDEADBEEF, 0,32'h04));
    tv.push_back(mk(0,1,32'h04,1,32'h0,        1,32'hDEADBEEF, 0,32'h04));
    // conflict at index 0: 0x00 then 0x40 then 0x00
    tv.push_back(mk(0,1,32'h00,0,32'h0,        0,32'h0,        0,32'h04));
    tv.push_back(mk(0,1,32'h00,0,32'h11111111, 0,32'h0,        1,32'h00));
    tv.push_back(mk(0,1,32'h00,0,32'h0,        1,32'h11111111, 0,32'h00));
    tv.push_back(mk(0,1,32'h40,0,32'h0,        0,32'h0,        0,32'h00));
    tv.push_back(mk(0,1,32'h40,0,32'h22222222, 0,32'h0,        1,32'h40));
    tv.push_back(mk(0,1,32'h40,0,32'h0,        1,32'h22222222, 0,32'h40));
    tv.push_back(mk(0,1,32'h00,0,32'h0,        0,32'h0,        0,32'h40));
    tv.push_back(mk(0,1,32'h00,1,32'h0,        0,32'h0,        1,32'h00));
    tv.push_back(mk(0,1,32'h00,0,32'h11111111, 0,32'h0,        1,32'h00));
    tv.push_back(mk(0,1,32'h00,0,32'h0,        1,32'h11111111, 0,32'h00));
    // redirect during FILL: miss 0x8, fetch moves to 0xC
    tv.push_back(mk(0,1,32'h08,0,32'h0,        0,32'h0,        0,32'h00));
    tv.push_back(mk(0,1,32'h0C,1,32'h0,        0,32'h0,        1,32'h08));
    tv.push_back(mk(0,1,32'h0C,0,32'hAAAA0008, 0,32'h0,        1,32'h08));
    tv.push_back(mk(0,1,32'h0C,0,32'h0,        0,32'h0,        0,32'h08));
    tv.push_back(mk(0,1,32'h0C,0,32'hCCCC000C, 0,32'h0,        1,32'h0C));
    tv.push_back(mk(0,1,32'h08,0,32'h0,        1,32'hAAAA0008, 0,32'h0C));
    tv.push_back(mk(0,1,32'h0C,0,32'h0,        1,32'hCCCC000C, 0,32'h0C));
    // reset mid-FILL while iwait=1
    tv.push_back(mk(0,1,32'h10,0,32'h0,        0,32'h0,        0,32'h0C));
    tv.push_back(mk(1,1,32'h10,1,32'h55555555, 0,32'h0,        1,32'h10));
    tv.push_back(mk(0,1,32'h10,0,32'h55555555, 0,32'h0,        0,32'h00));
    tv.push_back(mk(0,1,32'h10,0,32'h66666666, 0,32'h0,        1,32'h10));
    tv.push_back(mk(0,1,32'h10,0,32'h0,        1,32'h66666666, 0,32'h10));
    // lines filled before reset are gone
    tv.push_back(mk(0,1,32'h04,0,32'h0,        0,32'h0,        0,32'h10));
    tv.push_back(mk(0,1,32'h04,0,32'hDEADBEEF, 0,32'h0,        1,32'h04));
    tv.push_back(mk(0,1,32'h04,0,32'h0,        1,32'hDEADBEEF, 0,32'h04));
    // reset overrides a fill completing on the same edge
    tv.push_back(mk(0,1,32'h14,0,32'h0,        0,32'h0,        0,32'h04));
    tv.push_back(mk(1,1,32'h14,0,32'h77777777, 0,32'h0,        1,32'h14));
    tv.push_back(mk(0,1,32'h14,0,32'h0,        0,32'h0,        0,32'h00));
    tv.push_back(mk(0,1,32'h14,0,32'h88888888, 0,32'h0,        1,32'h14));
    tv.push_back(mk(0,1,32'h14,0,32'h0,        1,32'h88888888, 0,32'h14));
    // no request: everything quiet even though the line is valid
    tv.push_back(mk(0,0,32'h14,0,32'h0,        0,32'h0,        0,32'h14));

    RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Table: drive on negedge, sample 1 time unit later, before next posedge.
    for (int i = 0; i < tv.size(); i++) begin
      RST = tv[i].rst; imemREN = tv[i].ren; imemaddr = tv[i].addr;
      iwait = tv[i].iw; iload = tv[i].ld;
      #1;
      chk("ihit",     i, 32'(ihit),     32'(tv[i].e_hit));
      chk("imemload", i, imemload,      tv[i].e_load);
      chk("iREN",     i, 32'(iREN),     32'(tv[i].e_ren));
      chk("iaddr",    i, iaddr,         tv[i].e_addr);
      @(negedge CLK);
    end

    // Idle: 10 cycles with no request and random address/iwait.
    RST = 1'b0; imemREN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      imemaddr = $urandom; iwait = 1'($urandom); iload = $urandom;
      #1;
      chk("idle_ihit",     100 + k, 32'(ihit), 32'h0);
      chk("idle_imemload", 100 + k, imemload,  32'h0);
      chk("idle_iREN",     100 + k, 32'(iREN), 32'h0);
      @(negedge CLK);
    end

    // Long miss: iwait high for 4 FILL cycles, so 5 FILL cycles and hit in cycle 6.
    begin
      int hit_cycle;
      hit_cycle = -1;
      imemREN = 1'b1; imemaddr = 32'h0000_003C; iload = 32'h1234_5678;
      for (int k = 0; k < 20 && hit_cycle < 0; k++) begin
        iwait = (k < 5) ? 1'b1 : 1'b0;
        #1;
        if (ihit) begin
          hit_cycle = k;
          chk("long_imemload", 200, imemload, 32'h1234_5678);
        end
        @(negedge CLK);
      end
      if (hit_cycle < 0) begin
        checks++; failures++;
        $display("FAIL long_miss_timeout actual=no_hit required=hit_in_cycle_6");
      end else begin
        chk("long_hit_cycle", 201, 32'(hit_cycle), 32'd6);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
